// File: rtl/multi_pulse_pkg.sv
// Shared constants and types for the multi-channel pulse generator.
package multi_pulse_pkg;

    localparam int unsigned ADDR_CTRL     = 0;
    localparam int unsigned ADDR_PERIOD   = 1;
    localparam int unsigned ADDR_PRE_LEAD = 2;
    localparam int unsigned ADDR_CH_BASE  = 3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_window.sv
// Per-channel window decode: pulse-active and receiver pre-blanking flags for the current count.
module pulse_window #(
    parameter int unsigned CW = 16
) (
    input  logic [CW-1:0] cnt_i,
    input  logic [CW-1:0] delay_i,
    input  logic [CW-1:0] width_i,
    input  logic [CW-1:0] pre_lead_i,
    output logic          active_o_c,
    output logic          pre_o_c
);

    localparam int unsigned XW = CW + 1;

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] start_x;
    logic [XW-1:0] end_x;
    logic [XW-1:0] lead_x;

    // One extra bit keeps delay+width and cnt+pre_lead from wrapping.
    assign cnt_x   = {1'b0, cnt_i};
    assign start_x = {1'b0, delay_i};
    assign end_x   = {1'b0, delay_i} + {1'b0, width_i};
    assign lead_x  = {1'b0, cnt_i} + {1'b0, pre_lead_i};

    assign active_o_c = (width_i != '0) && (cnt_x >= start_x) && (cnt_x < end_x);
    assign pre_o_c    = (width_i != '0) && (lead_x >= start_x) && (cnt_x < end_x);

endmodule

// File: rtl/multi_pulse_gen.sv
// NCH-channel pulse generator with sync and pre-block outputs, timed from one period counter.
// Timing registers are double-buffered and committed at period boundaries.
module multi_pulse_gen
    import multi_pulse_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 16,
    parameter int unsigned AW  = 5
) (
    input  logic           clk_pll,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [CW-1:0]  wr_data,
    output logic [NCH-1:0] pulse,
    output logic           sync,
    output logic           pre_block,
    output logic           busy
);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic ctrl_en_q, ctrl_en_d;
    logic ctrl_os_q, ctrl_os_d;

    logic [CW-1:0] period_sh_q, period_sh_d;
    logic [CW-1:0] lead_sh_q, lead_sh_d;
    logic [NCH-1:0][CW-1:0] delay_sh_q, delay_sh_d;
    logic [NCH-1:0][CW-1:0] width_sh_q, width_sh_d;

    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] lead_q, lead_d;
    logic [NCH-1:0][CW-1:0] delay_q, delay_d;
    logic [NCH-1:0][CW-1:0] width_q, width_d;

    logic [NCH-1:0] pulse_q, pulse_d;
    logic sync_q, sync_d;
    logic pre_q, pre_d;
    logic busy_q, busy_d;

    logic [NCH-1:0] act_c;
    logic [NCH-1:0] pre_c;
    logic [CW-1:0]  per_eff_c;
    logic           last_c;
    logic           commit_c;
    logic           clr_en_c;

    assign per_eff_c = (period_q < CW'(2)) ? CW'(2) : period_q;
    assign last_c    = (state_q == RUN) && (cnt_q == per_eff_c - CW'(1));
    assign commit_c  = (state_q == IDLE) || last_c;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_window #(.CW(CW)) u_win (
            .cnt_i      (cnt_q),
            .delay_i    (delay_q[g]),
            .width_i    (width_q[g]),
            .pre_lead_i (lead_q),
            .active_o_c (act_c[g]),
            .pre_o_c    (pre_c[g])
        );
    end

    // Register writes, CTRL side effects and shadow-to-active commit.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_os_d   = ctrl_os_q;
        period_sh_d = period_sh_q;
        lead_sh_d   = lead_sh_q;
        delay_sh_d  = delay_sh_q;
        width_sh_d  = width_sh_q;
        period_d    = period_q;
        lead_d      = lead_q;
        delay_d     = delay_q;
        width_d     = width_q;

        if (clr_en_c) begin
            ctrl_en_d = 1'b0;
        end

        if (wr_en) begin
            if (wr_addr == AW'(ADDR_CTRL)) begin
                ctrl_en_d = wr_data[CTRL_EN_BIT];
                ctrl_os_d = wr_data[CTRL_ONESHOT_BIT];
            end
            if (wr_addr == AW'(ADDR_PERIOD)) begin
                period_sh_d = wr_data;
            end
            if (wr_addr == AW'(ADDR_PRE_LEAD)) begin
                lead_sh_d = wr_data;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wr_addr == AW'(ADDR_CH_BASE + 2 * i)) begin
                    delay_sh_d[i] = wr_data;
                end
                if (wr_addr == AW'(ADDR_CH_BASE + 2 * i + 1)) begin
                    width_sh_d[i] = wr_data;
                end
            end
        end

        // Commit uses the pre-write shadow, so a same-cycle write waits for the next commit.
        if (commit_c) begin
            period_d = period_sh_q;
            lead_d   = lead_sh_q;
            delay_d  = delay_sh_q;
            width_d  = width_sh_q;
        end
    end

    // Period FSM and registered output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_en_c = 1'b0;
        pulse_d  = '0;
        sync_d   = 1'b0;
        pre_d    = 1'b0;
        busy_d   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ctrl_en_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pulse_d = act_c;
                sync_d  = (cnt_q == '0);
                pre_d   = |pre_c;
                if (last_c) begin
                    cnt_d = '0;
                    if (ctrl_os_q) begin
                        clr_en_c = 1'b1;
                        state_d  = IDLE;
                    end else if (!ctrl_en_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ctrl_en_q   <= 1'b0;
            ctrl_os_q   <= 1'b0;
            period_sh_q <= '0;
            lead_sh_q   <= '0;
            delay_sh_q  <= '0;
            width_sh_q  <= '0;
            period_q    <= '0;
            lead_q      <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            pulse_q     <= '0;
            sync_q      <= 1'b0;
            pre_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_os_q   <= ctrl_os_d;
            period_sh_q <= period_sh_d;
            lead_sh_q   <= lead_sh_d;
            delay_sh_q  <= delay_sh_d;
            width_sh_q  <= width_sh_d;
            period_q    <= period_d;
            lead_q      <= lead_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            pulse_q     <= pulse_d;
            sync_q      <= sync_d;
            pre_q       <= pre_d;
            busy_q      <= busy_d;
        end
    end

    assign pulse     = pulse_q;
    assign sync      = sync_q;
    assign pre_block = pre_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen: output traces per clock compared against hand-derived windows.
module tb_multi_pulse_gen;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned AW  = 5;
    localparam int unsigned TRN = 1024;

    logic           clk_pll;
    logic           rst_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [CW-1:0]  wr_data;
    logic [NCH-1:0] pulse;
    logic           sync;
    logic           pre_block;
    logic           busy;

    multi_pulse_gen #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk_pll   (clk_pll),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pulse     (pulse),
        .sync      (sync),
        .pre_block (pre_block),
        .busy      (busy)
    );

    initial begin
        clk_pll = 1'b0;
        forever #5 clk_pll = ~clk_pll;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // cyc counts rising edges; trace[k] holds the outputs settled after edge k.
    int unsigned cyc = 0;
    always @(posedge clk_pll) cyc <= cyc + 1;

    logic [NCH-1:0] pul_tr  [0:TRN-1];
    logic           sync_tr [0:TRN-1];
    logic           pre_tr  [0:TRN-1];
    logic           busy_tr [0:TRN-1];

    always @(negedge clk_pll) begin
        if (cyc < TRN) begin
            pul_tr[cyc]  <= pulse;
            sync_tr[cyc] <= sync;
            pre_tr[cyc]  <= pre_block;
            busy_tr[cyc] <= busy;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] m(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
        for (int k = lo; k <= hi; k++) v[k] = 1'b1;
        return v;
    endfunction

    // sel: 0 sync, 1 pre_block, 2 busy, 3 pulse[0], 4 pulse[1]
    function automatic logic [63:0] tr(input int sel, input int unsigned base, input int n);
        logic [63:0] v;
        int unsigned idx;
        v = '0;
        for (int k = 0; k < n; k++) begin
            idx = base + k;
            case (sel)
                0:       v[k] = sync_tr[idx];
                1:       v[k] = pre_tr[idx];
                2:       v[k] = busy_tr[idx];
                3:       v[k] = pul_tr[idx][0];
                default: v[k] = pul_tr[idx][1];
            endcase
        end
        return v;
    endfunction

    task automatic win5(input string tag, input int unsigned base, input int n,
                        input logic [63:0] es, input logic [63:0] ep, input logic [63:0] eb,
                        input logic [63:0] e0, input logic [63:0] e1);
        chk({tag, "_sync"},   tr(0, base, n), es);
        chk({tag, "_pre"},    tr(1, base, n), ep);
        chk({tag, "_busy"},   tr(2, base, n), eb);
        chk({tag, "_pulse0"}, tr(3, base, n), e0);
        chk({tag, "_pulse1"}, tr(4, base, n), e1);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk_pll);
    endtask

    // Drive a write so that it is sampled by rising edge n.
    task automatic wr_at(input int unsigned n, input int unsigned a, input int unsigned d);
        wait_cyc(n - 1);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = CW'(d);
        @(negedge clk_pll);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_pll);
        rst_n = 1'b0;
        @(negedge clk_pll);
        @(negedge clk_pll);
        rst_n = 1'b1;
    endtask

    int unsigned t, u, v, r, w, x;

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wait_cyc(2);
        chk("reset_outs", 64'({pulse, sync, pre_block, busy}), 64'd0);
        rst_n = 1'b1;

        // PERIOD=10, PRE_LEAD=1, ch0 delay 2 width 3, ch1 delay 8 width 5 (truncated to cnt 8,9)
        wr_at(10, 1, 10);
        wr_at(11, 2, 1);
        wr_at(12, 3, 2);
        wr_at(13, 4, 3);
        wr_at(14, 5, 8);
        wr_at(15, 6, 5);
        t = 20;
        wr_at(t, 0, 1);
        wr_at(t + 33, 4, 1);
        wait_cyc(t + 41);
        win5("run", t, 40,
             m(2, 2) | m(12, 12) | m(22, 22) | m(32, 32),
             m(3, 6) | m(9, 11) | m(13, 16) | m(19, 21) | m(23, 26) | m(29, 31) | m(33, 36) | m(39, 39),
             m(2, 39),
             m(4, 6) | m(14, 16) | m(24, 26) | m(34, 36),
             m(10, 11) | m(20, 21) | m(30, 31));

        // WIDTH0 written at cnt=9 is held back one extra period
        wr_at(t + 51, 4, 2);
        wait_cyc(t + 61);
        chk("width_commit_pulse0", tr(3, t + 40, 20), m(4, 4) | m(14, 14));

        // Clear enable at cnt=4: period runs to cnt=9, then IDLE
        wr_at(t + 66, 0, 0);
        wait_cyc(t + 81);
        win5("stop", t + 60, 20,
             m(2, 2),
             m(0, 1) | m(3, 5) | m(9, 11),
             m(0, 11),
             m(4, 5),
             m(0, 1) | m(10, 11));

        // Oneshot: single period, enable cleared by hardware
        u = t + 90;
        wr_at(u, 0, 3);
        wait_cyc(u + 31);
        win5("oneshot", u, 30,
             m(2, 2),
             m(3, 5) | m(9, 11),
             m(2, 11),
             m(4, 5),
             m(10, 11));
        chk("oneshot_en_cleared", 64'(dut.ctrl_en_q), 64'd0);

        // Asynchronous reset while pulse[0] is high (cnt=3)
        v = u + 40;
        wr_at(v, 0, 1);
        wait_cyc(v + 4);
        chk("pre_rst_state", 64'({pulse[0], busy}), 64'd3);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 64'({pulse, sync, pre_block, busy}), 64'd0);
        @(negedge clk_pll);
        @(negedge clk_pll);
        rst_n = 1'b1;
        r = cyc;
        wait_cyc(r + 21);
        win5("post_rst", r, 20, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        chk("post_rst_en", 64'(dut.ctrl_en_q), 64'd0);

        // PERIOD=0 behaves as 2; DELAY0=0 with PRE_LEAD=5; WIDTH1=0 never fires
        w = r + 25;
        wr_at(w, 4, 1);
        wr_at(w + 1, 2, 5);
        wr_at(w + 5, 0, 1);
        wait_cyc(w + 18);
        win5("per0", w + 5, 12,
             m(2, 2) | m(4, 4) | m(6, 6) | m(8, 8) | m(10, 10),
             m(2, 2) | m(4, 4) | m(6, 6) | m(8, 8) | m(10, 10),
             m(2, 11),
             m(2, 2) | m(4, 4) | m(6, 6) | m(8, 8) | m(10, 10),
             64'd0);

        // Max DELAY/WIDTH: no wrap in the window sums; PRE_LEAD=0xFFF8 opens pre-block at cnt>=7
        do_reset();
        x = cyc + 2;
        wr_at(x, 1, 10);
        wr_at(x + 1, 3, 'hFFFF);
        wr_at(x + 2, 4, 'hFFFF);
        wr_at(x + 3, 2, 'hFFF8);
        wr_at(x + 4, 5, 3);
        wr_at(x + 8, 0, 1);
        wait_cyc(x + 34);
        win5("ovf", x + 8, 24,
             m(2, 2) | m(12, 12) | m(22, 22),
             m(9, 11) | m(19, 21),
             m(2, 23),
             64'd0,
             64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
